// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//
// Buffers one NxN A matrix and one NxN B matrix, loaded a row at a time, and
// on start streams them into a systolic array with diagonal skew: A row i is
// delayed i beats and B column j is delayed j beats, with zero padding. The
// array enable is held for the whole feed-plus-drain window (3N-2 cycles) so
// every C[i][j] finishes, and done pulses once afterwards.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous reset, active low
//   load_valid  a row pair is presented on load_a_row / load_b_row
//   load_ready  row pair is accepted this cycle (high only in LOAD)
//   load_a_row  A[r][k] at [k*BIT_WIDTH +: BIT_WIDTH]
//   load_b_row  B[r][k] at [k*BIT_WIDTH +: BIT_WIDTH]
//   start       begin streaming; honoured only in READY
//   busy        high while feeding or draining
//   A_out       array A input, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   B_out       array B input, lane j at [j*BIT_WIDTH +: BIT_WIDTH]
//   sa_enable   array enable
//   done        one-cycle pulse in the first LOAD cycle after a run
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int N         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [BIT_WIDTH*N-1:0] load_a_row,
    input  logic [BIT_WIDTH*N-1:0] load_b_row,
    input  logic                   start,
    output logic                   busy,
    output logic [BIT_WIDTH*N-1:0] A_out,
    output logic [BIT_WIDTH*N-1:0] B_out,
    output logic                   sa_enable,
    output logic                   done
);

    localparam int CW = $clog2(3*N-2);
    localparam int VW = BIT_WIDTH*N;

    localparam logic [CW-1:0] ROW_LAST   = CW'(N-1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(3*N-3);

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_row_cnt;
    logic [CW-1:0]     r_beat_cnt;
    logic              r_done;
    logic [VW-1:0]     r_a_out;
    logic [VW-1:0]     r_b_out;

    logic [BIT_WIDTH-1:0] r_a_buf [N][N];
    logic [BIT_WIDTH-1:0] r_b_buf [N][N];

    state_t            w_state_nxt;
    logic [CW-1:0]     w_row_nxt;
    logic [CW-1:0]     w_beat_nxt;
    logic              w_done_nxt;
    logic              w_load_fire;
    logic [VW-1:0]     w_a_nxt;
    logic [VW-1:0]     w_b_nxt;

    // ------------------------------------------------------------------
    // Next-state, counters and the next beat's lane values.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_row_nxt   = r_row_cnt;
        w_beat_nxt  = r_beat_cnt;
        w_done_nxt  = 1'b0;
        w_load_fire = 1'b0;

        case (r_state)
            S_LOAD: begin
                if (load_valid) begin
                    w_load_fire = 1'b1;
                    if (r_row_cnt == ROW_LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = S_READY;
                    end else begin
                        w_row_nxt = r_row_cnt + 1'b1;
                    end
                end
            end
            S_READY: begin
                if (start) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                w_beat_nxt = r_beat_cnt + 1'b1;
                if (r_beat_cnt == FEED_LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_beat_cnt == DRAIN_LAST) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_LOAD;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        // Lanes are registered, so they are computed for the beat about to
        // start. Element (i,k) sits on the diagonal t = i + k: A[i][k] goes
        // out on A lane i and B[i][k] on B lane k. Everything else is zero.
        w_a_nxt = '0;
        w_b_nxt = '0;
        if (w_state_nxt == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (w_beat_nxt == CW'(i + k)) begin
                        w_a_nxt[i*BIT_WIDTH +: BIT_WIDTH] = r_a_buf[i][k];
                        w_b_nxt[k*BIT_WIDTH +: BIT_WIDTH] = r_b_buf[i][k];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset) begin
            r_state    <= S_LOAD;
            r_row_cnt  <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_a_out    <= '0;
            r_b_out    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_cnt  <= w_row_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_done     <= w_done_nxt;
            r_a_out    <= w_a_nxt;
            r_b_out    <= w_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Matrix buffers.
    // NOTE: the buffers have no reset; their contents are meaningless until
    // reloaded, and leaving them out keeps them mappable to plain storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            for (int r = 0; r < N; r++) begin
                if (r_row_cnt == CW'(r)) begin
                    for (int k = 0; k < N; k++) begin
                        r_a_buf[r][k] <= load_a_row[k*BIT_WIDTH +: BIT_WIDTH];
                        r_b_buf[r][k] <= load_b_row[k*BIT_WIDTH +: BIT_WIDTH];
                    end
                end
            end
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign busy       = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign sa_enable  = busy;
    assign done       = r_done;
    assign A_out      = r_a_out;
    assign B_out      = r_b_out;

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of Systolic_Array: buffers one N×N A matrix and one N×N B matrix, loaded row by row.
- On start, streams them into the array with diagonal skew: row i of A is delayed i beats and column j of B is delayed j beats, zero-padded.
- Generates sa_enable for the full feed-plus-drain window so every C[i][j] completes.
- Replaces the hand-built skew tables currently kept in the bench.

Parameters:
BIT_WIDTH, 8, element width in bits (unsigned)
N, 4, array dimension; legal range 2..16

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
load_valid  input  1  a row is presented on load_a_row/load_b_row
load_ready  output  1  block accepts a row this cycle
load_a_row  input  BIT_WIDTH*N  row r of A; element A[r][k] at bits [k*BIT_WIDTH +: BIT_WIDTH]
load_b_row  input  BIT_WIDTH*N  row r of B; element B[r][k] at bits [k*BIT_WIDTH +: BIT_WIDTH]
start  input  1  begin streaming; honoured only in READY
busy  output  1  high in FEED and DRAIN
A_out  output  BIT_WIDTH*N  to Systolic_Array.A; lane i at [i*BIT_WIDTH +: BIT_WIDTH]
B_out  output  BIT_WIDTH*N  to Systolic_Array.B; lane j at [j*BIT_WIDTH +: BIT_WIDTH]
sa_enable  output  1  to Systolic_Array.enable
done  output  1  one-cycle pulse after the last drain beat

Behaviour:
Reset:
- While reset==0 at a rising edge: state=LOAD, row_cnt=0, beat_cnt=0.
- Outputs after that edge: A_out=0, B_out=0, sa_enable=0, busy=0, done=0, load_ready=1.
- Buffer contents are don't-care.
- Reset mid-operation, in any state, aborts; the next cycle shows reset values and the matrices must be reloaded.

States:
- LOAD:
  - load_ready=1.
  - Handshake fires when load_valid && load_ready: both rows are written into buffer row row_cnt, then row_cnt increments.
  - When the accepted row is N-1: row_cnt returns to 0 and state goes to READY.
  - load_valid=0 stalls with no state change.
- READY:
  - load_ready=0; load_valid is ignored.
  - When start==1 at an edge: beat_cnt=0 and state goes to FEED.
  - start asserted in any other state is ignored and is not remembered.
- FEED:
  - Beats t=0..2N-2, one per cycle; t=0 is the cycle immediately after the edge that sampled start.
  - All outputs are registered and valid during beat t.
  - A_out lane i = A[i][t-i] if 0 ≤ t-i ≤ N-1, else 0.
  - B_out lane j = B[t-j][j] if 0 ≤ t-j ≤ N-1, else 0.
  - sa_enable=1, busy=1.
  - After beat 2N-2, state goes to DRAIN.
- DRAIN:
  - Beats t=2N-1..3N-3 (N-1 cycles).
  - A_out=0, B_out=0, sa_enable=1, busy=1.
- Exit from DRAIN:
  - After beat 3N-3, state returns to LOAD.
  - In that first LOAD cycle: done=1 for exactly one cycle, sa_enable=0, busy=0, load_ready=1.
  - A new load may be accepted in that same cycle.

Totals and arithmetic:
- sa_enable stays high for exactly 3N-2 consecutive cycles per start.
- No arithmetic is performed on data; elements pass through unmodified.
- Zero padding is exact zeros.
- Counter widths are $clog2(3N-2); counters never wrap within a run.

Test Plan:
(All with N=4, BIT_WIDTH=8; A[r][k]=4r+k+1; B[r][k]=4r+k+17.)
1. Reset pulse (reset=0 for 2 cycles), then reset=1 → A_out=0, B_out=0, sa_enable=0, busy=0, done=0, load_ready=1.
2. Load 4 rows back-to-back, then start → load_ready drops after the 4th accept, and the following values appear in FEED:
   - Beat 0: A_out lanes[0..3] = 1,0,0,0.
   - Beat 3: A_out lanes[0..3] = 4,7,10,13; B_out lanes[0..3] = 29,26,23,20.
   - Beat 6: A_out lanes = 0,0,0,16; B_out lanes = 0,0,0,32.
3. Full run timing → sa_enable high for exactly 10 cycles; A_out and B_out are 0 in beats 7–9; done pulses once on cycle 11 with load_ready=1.
4. Loading with load_valid toggled 1,0,1,0,… plus start asserted during LOAD → rows are still stored in order, and the early start is ignored (no FEED until a start in READY).
5. Reset asserted at FEED beat 3 → the next cycle shows all outputs 0 and state LOAD; after reload and start, a full correct run is produced.
6. Extra start and load_valid pulses held during FEED/DRAIN → no effect; the stream is identical to scenario 2 and load_ready stays 0 until done.

Integration check: feed Systolic_Array (N=4), hold for 10 cycles → C_out equals the A×B golden model.
